// File: rtl/prbs_lfsr_chk_pkg.sv
// ---------------------------------------------------------------------------
// prbs_pkg
//   Shared constants for the PRBS generator/checker:
//   - checker FSM state encoding (exposed on the FSM_o debug port)
//   - feedback tap masks for the common PRBS polynomials
//     (bit k of a mask stands for the term x^(k+1))
// ---------------------------------------------------------------------------
package prbs_pkg;

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_LOCK   = 2'd2;

    localparam logic [6:0]  PRBS7_TAPS  = 7'h60;
    localparam logic [14:0] PRBS15_TAPS = 15'h6000;
    localparam logic [22:0] PRBS23_TAPS = 23'h420000;
    localparam logic [24:0] PRBS25_TAPS = 25'h1200000;
    localparam logic [30:0] PRBS31_TAPS = 31'h48000000;

endpackage

// File: rtl/prbs_lfsr_chk_step.sv
// ---------------------------------------------------------------------------
// prbs_lfsr_step
//   Combinational LFSR step: feedback bit and shifted next state.
//   Used once for the TX generator and once for the RX checker.
// Ports:
//   state    in  C_W  current LFSR contents
//   din      in  1    bit shifted into position 0
//   fb       out 1    feedback bit of the current state
//   state_nx out C_W  state after shifting din in
// ---------------------------------------------------------------------------
module prbs_lfsr_step #(
    parameter int              C_W    = 25,
    parameter logic [C_W-1:0]  C_TAPS = 25'h1200000
) (
    input  logic [C_W-1:0] state,
    input  logic           din,
    output logic           fb,
    output logic [C_W-1:0] state_nx
);

    // The OR term kicks the register out of the all-zero lockup state.
    assign fb       = (^(state & C_TAPS)) | (state == '0);
    assign state_nx = {state[C_W-2:0], din};

endmodule

// File: rtl/prbs_lfsr_chk.sv
// ---------------------------------------------------------------------------
// prbs_lfsr_chk
//   PRBS generator plus self-synchronising checker for link bring-up and
//   BER measurement. TX free-runs an LFSR onto TXD_o; RX aligns its own LFSR
//   to RXD_i (SEARCH -> SYNC -> LOCK), then counts bit errors and drops lock
//   when too many errors land in one window.
// Ports:
//   CK_i       in  1      clock
//   XARST_i    in  1      async reset, active low
//   CK_EE_i    in  1      clock enable; low = every register holds
//   RESTART_i  in  1      sync checker restart (TX unaffected), needs CK_EE_i
//   RXD_i      in  1      received serial bit
//   TXD_o      out 1      generated PRBS bit
//   CMP_o      out 1      registered RX bit == expected bit
//   LOCK_o     out 1      checker in LOCK
//   ERR_o      out 1      one-enabled-cycle pulse per counted error
//   ERRCNT_o   out C_ECW  saturating error count
//   Xs_o       out C_W    checker LFSR state
//   FSM_o      out 2      checker FSM state (debug)
// Handshake: there is no valid/ready pair; every cycle with CK_EE_i=1
//   consumes one RXD_i bit and produces one TXD_o/CMP_o bit.
// ---------------------------------------------------------------------------
module prbs_lfsr_chk
    import prbs_pkg::*;
#(
    parameter int             C_W      = 25,
    parameter logic [C_W-1:0] C_TAPS   = 25'h1200000,
    parameter int             C_LOCK_N = 32,
    parameter int             C_WIN_N  = 64,
    parameter int             C_LOSS_N = 8,
    parameter int             C_ECW    = 16
) (
    input  logic             CK_i,
    input  logic             XARST_i,
    input  logic             CK_EE_i,
    input  logic             RESTART_i,
    input  logic             RXD_i,
    output logic             TXD_o,
    output logic             CMP_o,
    output logic             LOCK_o,
    output logic             ERR_o,
    output logic [C_ECW-1:0] ERRCNT_o,
    output logic [C_W-1:0]   Xs_o,
    output logic [1:0]       FSM_o
);

    localparam int LCW = $clog2(C_W + 1);
    localparam int MCW = $clog2(C_LOCK_N + 1);
    localparam int WCW = $clog2(C_WIN_N + 1);
    localparam int WEW = $clog2(C_LOSS_N + 2);

    localparam logic [LCW-1:0] LOAD_LAST  = LCW'(C_W - 1);
    localparam logic [MCW-1:0] MATCH_LAST = MCW'(C_LOCK_N - 1);
    localparam logic [WCW-1:0] WIN_LAST   = WCW'(C_WIN_N - 1);
    localparam logic [WEW-1:0] LOSS_LVL   = WEW'(C_LOSS_N);
    localparam bit             LOSS_EN    = (C_LOSS_N > 0);

    // Registers
    logic [C_W-1:0]   xt;
    logic [C_W-1:0]   xr;
    logic             txd;
    logic             cmp;
    logic             lock;
    logic             err;
    logic [C_ECW-1:0] errcnt;
    logic [1:0]       state;
    logic [LCW-1:0]   load_cnt;
    logic [MCW-1:0]   match_cnt;
    logic [WCW-1:0]   win_cnt;
    logic [WEW-1:0]   win_err;

    // Next-state values
    logic [C_W-1:0]   xt_nx;
    logic [C_W-1:0]   xr_nx;
    logic [C_W-1:0]   xr_shift;
    logic             tx_fb;
    logic             rx_exp;
    logic             rx_din;
    logic             match;
    logic             wrap;
    logic [WEW-1:0]   win_err_inc;
    logic             err_nx;
    logic [C_ECW-1:0] errcnt_nx;
    logic [1:0]       state_nx;
    logic [LCW-1:0]   load_nx;
    logic [MCW-1:0]   match_nx;
    logic [WCW-1:0]   win_nx;
    logic [WEW-1:0]   win_err_nx;

    prbs_lfsr_step #(.C_W(C_W), .C_TAPS(C_TAPS)) u_tx_step (
        .state    (xt),
        .din      (tx_fb),
        .fb       (tx_fb),
        .state_nx (xt_nx)
    );

    // In LOCK the checker free-runs on its own prediction so one line error
    // is seen once instead of once per tap it passes through.
    assign rx_din = (state == ST_LOCK) ? rx_exp : RXD_i;

    prbs_lfsr_step #(.C_W(C_W), .C_TAPS(C_TAPS)) u_rx_step (
        .state    (xr),
        .din      (rx_din),
        .fb       (rx_exp),
        .state_nx (xr_shift)
    );

    assign match       = (rx_exp == RXD_i);
    assign wrap        = (win_cnt == WIN_LAST);
    assign win_err_inc = win_err + WEW'(!match);

    always_comb begin
        xr_nx      = xr_shift;
        state_nx   = state;
        load_nx    = load_cnt;
        match_nx   = match_cnt;
        win_nx     = win_cnt;
        win_err_nx = win_err;
        errcnt_nx  = errcnt;
        err_nx     = 1'b0;

        case (state)
            ST_SEARCH: begin
                if (load_cnt == LOAD_LAST) begin
                    state_nx = ST_SYNC;
                    load_nx  = '0;
                    match_nx = '0;
                end else begin
                    load_nx = load_cnt + LCW'(1);
                end
            end
            ST_SYNC: begin
                if (match) begin
                    if (match_cnt == MATCH_LAST) begin
                        state_nx   = ST_LOCK;
                        match_nx   = '0;
                        win_nx     = '0;
                        win_err_nx = '0;
                    end else begin
                        match_nx = match_cnt + MCW'(1);
                    end
                end else begin
                    match_nx = '0;
                end
            end
            ST_LOCK: begin
                win_nx = wrap ? '0 : win_cnt + WCW'(1);
                if (!match) begin
                    err_nx = 1'b1;
                    if (errcnt != '1) begin
                        errcnt_nx = errcnt + C_ECW'(1);
                    end
                end
                // Loss is judged on the window the error belongs to before
                // any wrap, so it wins over the wrap clearing the count.
                if (LOSS_EN && !match && (win_err_inc == LOSS_LVL)) begin
                    state_nx   = ST_SEARCH;
                    load_nx    = '0;
                    match_nx   = '0;
                    win_nx     = '0;
                    win_err_nx = '0;
                end else if (wrap) begin
                    win_err_nx = WEW'(!match);
                end else begin
                    win_err_nx = win_err_inc;
                end
            end
            default: begin
                state_nx = ST_SEARCH;
                load_nx  = '0;
                match_nx = '0;
            end
        endcase

        if (RESTART_i) begin
            state_nx   = ST_SEARCH;
            xr_nx      = '1;
            load_nx    = '0;
            match_nx   = '0;
            win_nx     = '0;
            win_err_nx = '0;
            errcnt_nx  = '0;
            err_nx     = 1'b0;
        end
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            xt        <= '1;
            xr        <= '1;
            txd       <= 1'b0;
            cmp       <= 1'b1;
            lock      <= 1'b0;
            err       <= 1'b0;
            errcnt    <= '0;
            state     <= ST_SEARCH;
            load_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
        end else if (CK_EE_i) begin
            xt        <= xt_nx;
            txd       <= tx_fb;
            xr        <= xr_nx;
            cmp       <= match;
            lock      <= (state_nx == ST_LOCK);
            err       <= err_nx;
            errcnt    <= errcnt_nx;
            state     <= state_nx;
            load_cnt  <= load_nx;
            match_cnt <= match_nx;
            win_cnt   <= win_nx;
            win_err   <= win_err_nx;
        end
    end

    // Gating with the enable keeps the error pulse to one enabled cycle even
    // when the enable is sparse.
    assign ERR_o    = err & CK_EE_i;
    assign TXD_o    = txd;
    assign CMP_o    = cmp;
    assign LOCK_o   = lock;
    assign ERRCNT_o = errcnt;
    assign Xs_o     = xr;
    assign FSM_o    = state;

endmodule

// File: tb/tb_prbs_lfsr_chk.sv
// ---------------------------------------------------------------------------
// tb_prbs_lfsr_chk
//   Three instances: A (PRBS25 defaults), B (PRBS7), C (PRBS7, 4-bit error
//   counter, loss detect off). Each runs in loopback with an optional
//   inversion on the return path. The reference TX sequence comes from the
//   polynomial recurrence h[n] = XOR of h[n-1-k] over set tap bits k.
// ---------------------------------------------------------------------------
module tb_prbs_lfsr_chk;

    typedef logic bq_t[$];

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic en_a, en_b, en_c;
    logic rs_a, rs_b, rs_c;
    logic inv_a, inv_b, inv_c;
    logic rxd_a, rxd_b, rxd_c;
    logic txd_a, txd_b, txd_c;
    logic cmp_a, cmp_b, cmp_c;
    logic lock_a, lock_b, lock_c;
    logic err_a, err_b, err_c;
    logic [15:0] errcnt_a, errcnt_b;
    logic [3:0]  errcnt_c;
    logic [24:0] xs_a;
    logic [6:0]  xs_b, xs_c;
    logic [1:0]  fsm_a, fsm_b, fsm_c;

    assign rxd_a = txd_a ^ inv_a;
    assign rxd_b = txd_b ^ inv_b;
    assign rxd_c = txd_c ^ inv_c;

    prbs_lfsr_chk #(.C_W(25), .C_TAPS(25'h1200000), .C_LOCK_N(32), .C_WIN_N(64),
                    .C_LOSS_N(8), .C_ECW(16)) dut_a (
        .CK_i(clk), .XARST_i(rst_n), .CK_EE_i(en_a), .RESTART_i(rs_a), .RXD_i(rxd_a),
        .TXD_o(txd_a), .CMP_o(cmp_a), .LOCK_o(lock_a), .ERR_o(err_a),
        .ERRCNT_o(errcnt_a), .Xs_o(xs_a), .FSM_o(fsm_a));

    prbs_lfsr_chk #(.C_W(7), .C_TAPS(7'h60), .C_LOCK_N(32), .C_WIN_N(64),
                    .C_LOSS_N(8), .C_ECW(16)) dut_b (
        .CK_i(clk), .XARST_i(rst_n), .CK_EE_i(en_b), .RESTART_i(rs_b), .RXD_i(rxd_b),
        .TXD_o(txd_b), .CMP_o(cmp_b), .LOCK_o(lock_b), .ERR_o(err_b),
        .ERRCNT_o(errcnt_b), .Xs_o(xs_b), .FSM_o(fsm_b));

    prbs_lfsr_chk #(.C_W(7), .C_TAPS(7'h60), .C_LOCK_N(32), .C_WIN_N(64),
                    .C_LOSS_N(0), .C_ECW(4)) dut_c (
        .CK_i(clk), .XARST_i(rst_n), .CK_EE_i(en_c), .RESTART_i(rs_c), .RXD_i(rxd_c),
        .TXD_o(txd_c), .CMP_o(cmp_c), .LOCK_o(lock_c), .ERR_o(err_c),
        .ERRCNT_o(errcnt_c), .Xs_o(xs_c), .FSM_o(fsm_c));

    // ---------------- bookkeeping ----------------
    int n_total = 0;
    int n_bad   = 0;
    int lock_t  = 0;
    int errp_a = 0, errp_b = 0, errp_c = 0;
    logic sb_on = 1'b0;
    logic rec_b = 1'b0;
    logic ee_a = 1'b0, ee_b = 1'b0, ee_c = 1'b0;
    logic prev_b = 1'b0;

    bq_t hist_a, hist_b, hist_c;
    logic [0:0] exp_qa[$];
    logic [0:0] exp_qb[$];
    logic [0:0] exp_qc[$];
    logic obs_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_total++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic seq_next(input bq_t h, input int w, input logic [31:0] taps);
        logic b;
        logic allz;
        b    = 1'b0;
        allz = 1'b1;
        for (int k = 0; k < w; k++) begin
            if (h[h.size()-1-k]) allz = 1'b0;
            if (taps[k]) b ^= h[h.size()-1-k];
        end
        return b | allz;
    endfunction

    task automatic reset_models();
        hist_a.delete(); hist_b.delete(); hist_c.delete();
        exp_qa.delete(); exp_qb.delete(); exp_qc.delete();
        for (int i = 0; i < 25; i++) hist_a.push_back(1'b1);
        for (int i = 0; i < 7; i++) begin
            hist_b.push_back(1'b1);
            hist_c.push_back(1'b1);
        end
    endtask

    // ---------------- driver ----------------
    // Sets the inputs for the coming edge, queues the expected TX bit for
    // every enabled instance, then returns 2 ns after that edge.
    task automatic step(input logic ea, input logic eb, input logic ec);
        logic b;
        en_a = ea; en_b = eb; en_c = ec;
        if (ea) begin
            b = seq_next(hist_a, 25, 32'h1200000);
            hist_a.push_back(b); hist_a.delete(0); exp_qa.push_back(b);
        end
        if (eb) begin
            b = seq_next(hist_b, 7, 32'h60);
            hist_b.push_back(b); hist_b.delete(0); exp_qb.push_back(b);
        end
        if (ec) begin
            b = seq_next(hist_c, 7, 32'h60);
            hist_c.push_back(b); hist_c.delete(0); exp_qc.push_back(b);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic run_a(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0);
            lock_t++;
        end
    endtask

    task automatic wait_lock_a(input string name);
        int n;
        n = 0;
        for (int i = 1; i <= 70 && n == 0; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (lock_a === 1'b1) n = i;
        end
        check_range(name, n, 57, 59);
        lock_t = 0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        ee_a <= en_a;
        ee_b <= en_b;
        ee_c <= en_c;
    end

    always @(negedge clk) begin
        logic [0:0] e;
        if (sb_on) begin
            if (ee_a) begin
                if (exp_qa.size() == 0) check("sb_a_underflow", 1, 0);
                else begin e = exp_qa.pop_front(); check("sb_txd_a", txd_a, e); end
            end
            if (ee_b) begin
                if (exp_qb.size() == 0) check("sb_b_underflow", 1, 0);
                else begin e = exp_qb.pop_front(); check("sb_txd_b", txd_b, e); end
                if (rec_b) obs_b.push_back(txd_b);
            end else begin
                check("hold_txd_b", txd_b, prev_b);
            end
            if (ee_c) begin
                if (exp_qc.size() == 0) check("sb_c_underflow", 1, 0);
                else begin e = exp_qc.pop_front(); check("sb_txd_c", txd_c, e); end
            end
        end
        prev_b = txd_b;
        if (err_a === 1'b1) errp_a++;
        if (err_b === 1'b1) errp_b++;
        if (err_c === 1'b1) errp_c++;
    end

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        n_bad++;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "simulation time limit reached");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n, cnt, k, mism, ones, e0;
        rst_n = 1'b0;
        en_a = 0; en_b = 0; en_c = 0;
        rs_a = 0; rs_b = 0; rs_c = 0;
        inv_a = 0; inv_b = 0; inv_c = 0;
        repeat (3) @(posedge clk);
        #2;

        // reset values
        check("rst_txd_a", txd_a, 0);
        check("rst_cmp_a", cmp_a, 1);
        check("rst_lock_a", lock_a, 0);
        check("rst_err_a", err_a, 0);
        check("rst_errcnt_a", errcnt_a, 0);
        check("rst_xs_a", xs_a, 25'h1ffffff);
        check("rst_fsm_a", fsm_a, 0);
        check("rst_xs_b", xs_b, 7'h7f);
        check("rst_cmp_b", cmp_b, 1);
        check("rst_fsm_b", fsm_b, 0);
        check("rst_xs_c", xs_c, 7'h7f);
        check("rst_fsm_c", fsm_c, 0);

        reset_models();
        rst_n = 1'b1;
        sb_on = 1'b1;

        // 1: loopback lock, then 4096 clean bits
        wait_lock_a("t1_lock_time");
        run_a(4096);
        check("t1_errcnt", errcnt_a, 0);
        check("t1_err_pulses", errp_a, 0);
        check("t1_lock", lock_a, 1);
        check("t1_fsm", fsm_a, 2);

        // 2: one inverted bit while locked
        e0 = errp_a;
        run_a($urandom_range(1, 40));
        inv_a = 1'b1;
        run_a(1);
        inv_a = 1'b0;
        check("t2_cmp_low", cmp_a, 0);
        run_a(1);
        check("t2_cmp_high", cmp_a, 1);
        run_a(10);
        check("t2_err_pulses", errp_a - e0, 1);
        check("t2_errcnt", errcnt_a, 1);
        check("t2_lock", lock_a, 1);

        // 5: restart while locked
        rs_a = 1'b1;
        run_a(1);
        rs_a = 1'b0;
        check("t5_lock", lock_a, 0);
        check("t5_errcnt", errcnt_a, 0);
        check("t5_fsm", fsm_a, 0);
        check("t5_xs", xs_a, 25'h1ffffff);
        wait_lock_a("t5_relock_time");

        // 3: eight errors inside one loss window
        run_a($urandom_range(0, 100));
        while ((lock_t % 64) != 0) run_a(1);
        run_a($urandom_range(0, 40));
        e0 = errp_a;
        for (int i = 0; i < 8; i++) begin
            inv_a = 1'b1;
            run_a(1);
            inv_a = 1'b0;
            if (i == 6) check("t3_lock_after7", lock_a, 1);
            if (i < 7) run_a($urandom_range(0, 2));
        end
        check("t3_lock_lost", lock_a, 0);
        check("t3_fsm_search", fsm_a, 0);
        check("t3_errcnt", errcnt_a, 8);
        wait_lock_a("t3_relock_time");
        check("t3_err_pulses", errp_a - e0, 8);
        check("t3_errcnt_kept", errcnt_a, 8);

        // 4: PRBS7 with a 1-of-3 enable
        n = 0; cnt = 0; k = 0;
        while (n == 0 && k < 3 * 45) begin
            step(1'b0, (k % 3) == 0, 1'b0);
            if ((k % 3) == 0) begin
                cnt++;
                if (lock_b === 1'b1) n = cnt;
            end
            k++;
        end
        check_range("t4_lock_time", n, 39, 41);
        rec_b = 1'b1;
        k = 0;
        while (obs_b.size() < 254 && k < 3000) begin
            step(1'b0, (k % 3) == 0, 1'b0);
            k++;
        end
        step(1'b0, 1'b0, 1'b0);
        rec_b = 1'b0;
        check("t4_obs_count", obs_b.size() >= 254, 1);
        if (obs_b.size() >= 254) begin
            mism = 0; ones = 0;
            for (int i = 0; i < 127; i++) begin
                if (obs_b[i] !== obs_b[i+127]) mism++;
                if (obs_b[i] === 1'b1) ones++;
            end
            check("t4_period127", mism, 0);
            check("t4_ones_per_period", ones, 64);
        end
        check("t4_err_pulses", errp_b, 0);
        check("t4_errcnt", errcnt_b, 0);
        check("t4_lock", lock_b, 1);

        // 6: saturating 4-bit counter, loss detect off, inverted return path
        n = 0;
        for (int i = 1; i <= 50 && n == 0; i++) begin
            step(1'b0, 1'b0, 1'b1);
            if (lock_c === 1'b1) n = i;
        end
        check_range("t6_lock_time", n, 39, 41);
        e0 = errp_c;
        inv_c = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
        check("t6_errcnt5", errcnt_c, 5);
        check("t6_cmp_low", cmp_c, 0);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b1);
        check("t6_errcnt_sat", errcnt_c, 15);
        check("t6_lock", lock_c, 1);
        inv_c = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        check("t6_err_pulses", errp_c - e0, 35);
        check("t6_errcnt_held", errcnt_c, 15);

        // asynchronous reset mid-operation
        sb_on = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_lock_a", lock_a, 0);
        check("arst_errcnt_a", errcnt_a, 0);
        check("arst_txd_a", txd_a, 0);
        check("arst_cmp_a", cmp_a, 1);
        check("arst_xs_a", xs_a, 25'h1ffffff);
        check("arst_fsm_a", fsm_a, 0);
        check("arst_lock_c", lock_c, 0);
        check("arst_errcnt_c", errcnt_c, 0);
        check("arst_cmp_c", cmp_c, 1);
        #20;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
